// File: rtl/seq_stream_checker.sv
// rtl/seq_stream_checker.sv - sink/checker for an incrementing addr/data beat stream
//
// Purpose:
//   Accepts beats over a valid/ready handshake, locks onto the first beat of a
//   run and then checks that every later beat carries addr and data equal to
//   the previous beat + 1 (mod 2^W). Counts beats and errors and captures the
//   first failing beat.
//
// Optional feature:
//   CHECKER_STOP_ON_ERR_EN - when defined, the first mismatch in CHECK ends
//   the run (HALT) on the same edge; when undefined, checking continues.
//
// Ports:
//   sys_clk         in   clock, all logic on posedge
//   sys_rst_n       in   asynchronous active-low reset
//   start           in   arm/re-arm pulse: clear counters/captures, enter SYNC
//   stop            in   abort run, return to IDLE (counters/captures held)
//   in_valid        in   beat valid
//   in_ready        out  beat accepted when in_valid & in_ready
//   in_addr         in   beat address
//   in_data         in   beat data
//   busy            out  state is SYNC or CHECK
//   done            out  run finished (HALT)
//   pass            out  done & no errors
//   err_pulse       out  one-cycle pulse after a mismatching beat is accepted
//   beat_cnt        out  accepted beats this run, saturating
//   err_cnt         out  mismatching beats this run, saturating
//   first_err_addr  out  in_addr of the first mismatching beat
//   first_err_data  out  in_data of the first mismatching beat

module seq_stream_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int NUM_BEATS  = 0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  err_pulse,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [DATA_WIDTH-1:0] first_err_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } state_t;

`ifdef CHECKER_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  localparam bit                 LIMIT_EN = (NUM_BEATS != 0);
  localparam logic [CNT_WIDTH-1:0] LIMIT  = CNT_WIDTH'(NUM_BEATS);

  state_t                state;
  logic [ADDR_WIDTH-1:0] exp_addr;
  logic [DATA_WIDTH-1:0] exp_data;

  logic                  accept;
  logic                  mismatch;
  logic                  run_end;
  logic [CNT_WIDTH-1:0]  beat_cnt_inc;
  logic [CNT_WIDTH-1:0]  err_cnt_inc;

  // Ready depends on state only so the source never sees a combinational
  // path from its own valid back to ready.
  assign in_ready = (state == SYNC) || (state == CHECK);
  assign busy     = in_ready;
  assign done     = (state == HALT);
  assign pass     = done && (err_cnt == '0);

  assign accept   = in_valid && in_ready;
  assign mismatch = (in_addr != exp_addr) || (in_data != exp_data);

  // Saturating increments: counters stick at all-ones instead of wrapping.
  assign beat_cnt_inc = (beat_cnt == '1) ? beat_cnt : beat_cnt + 1'b1;
  assign err_cnt_inc  = (err_cnt  == '1) ? err_cnt  : err_cnt  + 1'b1;

  // Run length is judged on the count this beat produces, so the HALT
  // transition happens on the same edge that accepts the last beat.
  assign run_end = LIMIT_EN && (beat_cnt_inc == LIMIT);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= IDLE;
      exp_addr       <= '0;
      exp_data       <= '0;
      err_pulse      <= 1'b0;
      beat_cnt       <= '0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (stop) begin
        // Stop beats start; any beat in flight this cycle is discarded and
        // all results are left in place for readback.
        state <= IDLE;
      end else if (start) begin
        // Re-arm from any state; a beat accepted in this cycle is dropped.
        state          <= SYNC;
        exp_addr       <= '0;
        exp_data       <= '0;
        beat_cnt       <= '0;
        err_cnt        <= '0;
        first_err_addr <= '0;
        first_err_data <= '0;
      end else begin
        case (state)
          SYNC: begin
            if (accept) begin
              exp_addr <= in_addr + 1'b1;
              exp_data <= in_data + 1'b1;
              beat_cnt <= beat_cnt_inc;
              state    <= run_end ? HALT : CHECK;
            end
          end
          CHECK: begin
            if (accept) begin
              // Always resync to the received beat so one glitch counts once.
              exp_addr <= in_addr + 1'b1;
              exp_data <= in_data + 1'b1;
              beat_cnt <= beat_cnt_inc;
              if (mismatch) begin
                err_cnt   <= err_cnt_inc;
                err_pulse <= 1'b1;
                if (err_cnt == '0) begin
                  first_err_addr <= in_addr;
                  first_err_data <= in_data;
                end
              end
              if ((mismatch && STOP_ON_ERR) || run_end) begin
                state <= HALT;
              end
            end
          end
          default: begin
            // IDLE and HALT only leave on start/stop, handled above.
            state <= state;
          end
        endcase
      end
    end
  end

endmodule
